seg7_reader: RTL and testbench

SEG7_READER -- requirements
Module: seg7_reader

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_encode.sv | 41 ++++
 rtl/seg7_reader.sv | 120 ++++++++++++
 tb/tb_seg7_reader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low hex glyph patterns
// (bit0 = segment a ... bit6 = segment g), the blank pattern and the
// step-direction encodings. Also used by the HEX display decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_t;

endpackage

// File: rtl/seg7_encode.sv
// Combinational seven-segment to hex encoder. The single place where the
// glyph table is decoded; hit flags a recognised glyph, blank flags all-off.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       hit,
  output logic       blank
);

  // Look the pattern up in the glyph table; anything else is a miss
  always_comb begin
    code  = 4'h0;
    hit   = 1'b1;
    blank = 1'b0;
    case (pattern)
      SEG_0: code = 4'h0;
      SEG_1: code = 4'h1;
      SEG_2: code = 4'h2;
      SEG_3: code = 4'h3;
      SEG_4: code = 4'h4;
      SEG_5: code = 4'h5;
      SEG_6: code = 4'h6;
      SEG_7: code = 4'h7;
      SEG_8: code = 4'h8;
      SEG_9: code = 4'h9;
      SEG_A: code = 4'hA;
      SEG_B: code = 4'hB;
      SEG_C: code = 4'hC;
      SEG_D: code = 4'hD;
      SEG_E: code = 4'hE;
      SEG_F: code = 4'hF;
      default: begin
        hit   = 1'b0;
        blank = (pattern == SEG_BLANK);
      end
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Reads an asynchronous active-low seven-segment pattern, debounces it,
// decodes it to a hex value and tracks counting direction and down-steps.
// A change on seg that stays put is reported STABLE_CYCLES+2 edges later.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [6:0]       seg,
  output logic [3:0]       value,
  output logic             valid,
  output logic             new_val,
  output logic             err,
  output logic [1:0]       dir,
  output logic [CNT_W-1:0] step_cnt
);

  // The counter saturates at STABLE_CYCLES-1; acceptance fires on the edge
  // that takes it there, so the pulse appears without an extra cycle.
  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] STAB_PRE = 8'(STABLE_CYCLES - 2);

  logic [6:0] sync1;
  logic [6:0] sync2;
  logic [6:0] cand;
  logic [6:0] last;
  logic [7:0] stab_cnt;
  dir_t       dir_q;

  logic       same;
  logic       accept;
  logic [3:0] code;
  logic       hit;
  logic       blank;
  logic [3:0] value_dn;
  logic [3:0] value_up;

  seg7_encode u_encode (
    .pattern (cand),
    .code    (code),
    .hit     (hit),
    .blank   (blank)
  );

  assign dir = dir_q;

  // Two-flop synchronizer; reset to blank so nothing is decoded at start-up
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= SEG_BLANK;
      sync2 <= SEG_BLANK;
    end else begin
      sync1 <= seg;
      sync2 <= sync1;
    end
  end

  // Acceptance decision and wrap-around neighbours of the current value
  always_comb begin
    same     = (sync2 == cand);
    accept   = same && (stab_cnt >= STAB_PRE) && (cand != last) && en;
    value_dn = value - 4'd1;
    value_up = value + 4'd1;
  end

  // Candidate tracking: any difference restarts the stability count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand     <= SEG_BLANK;
      stab_cnt <= 8'd0;
    end else if (!same) begin
      cand     <= sync2;
      stab_cnt <= 8'd0;
    end else if (stab_cnt != STAB_MAX) begin
      stab_cnt <= stab_cnt + 8'd1;
    end
  end

  // Registered outputs updated once per accepted pattern
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last     <= SEG_BLANK;
      value    <= 4'h0;
      valid    <= 1'b0;
      new_val  <= 1'b0;
      err      <= 1'b0;
      dir_q    <= DIR_NONE;
      step_cnt <= '0;
    end else begin
      new_val <= 1'b0;
      err     <= 1'b0;
      if (accept) begin
        last <= cand;
        if (hit) begin
          value   <= code;
          valid   <= 1'b1;
          new_val <= 1'b1;
          if (valid && (code == value_dn)) begin
            dir_q <= DIR_DOWN;
            if (step_cnt != '1)
              step_cnt <= step_cnt + CNT_W'(1);
          end else if (valid && (code == value_up)) begin
            dir_q <= DIR_UP;
          end else begin
            dir_q <= DIR_NONE;
          end
        end else begin
          valid <= 1'b0;
          dir_q <= DIR_NONE;
          err   <= !blank;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader: every pattern change expected to be
// accepted pushes an expected pulse record; the monitor pops and compares.
module tb_seg7_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [6:0] seg = 7'b1111111;
  logic [3:0] value;
  logic       valid;
  logic       new_val;
  logic       err;
  logic [1:0] dir;
  logic [7:0] step_cnt;

  seg7_reader #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .seg      (seg),
    .value    (value),
    .valid    (valid),
    .new_val  (new_val),
    .err      (err),
    .dir      (dir),
    .step_cnt (step_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    bit         is_err;
    logic [3:0] value;
    bit         valid;
    logic [1:0] dir;
    logic [7:0] step;
  } exp_t;

  exp_t sb[$];

  logic [6:0] glyph_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int tests_run = 0;
  int tests_failed = 0;
  int edge_cnt = 0;

  logic [3:0] m_value = 4'h0;
  bit         m_valid = 1'b0;
  logic [1:0] m_dir   = 2'b00;
  logic [7:0] m_step  = 8'h00;
  logic [6:0] m_last  = 7'b1111111;

  // Count rising edges so pulse latency can be checked
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of one acceptance; pushes the pulse it should cause
  task automatic modelAccept(input logic [6:0] pat, input int due);
    int   code;
    exp_t e;
    code = -1;
    for (int i = 0; i < 16; i++)
      if (glyph_tab[i] == pat) code = i;
    m_last = pat;
    if (code >= 0) begin
      if (m_valid && code[3:0] == 4'(m_value - 4'd1)) begin
        m_dir = 2'b10;
        if (m_step != 8'hFF) m_step = m_step + 8'd1;
      end else if (m_valid && code[3:0] == 4'(m_value + 4'd1)) begin
        m_dir = 2'b01;
      end else begin
        m_dir = 2'b00;
      end
      m_value = code[3:0];
      m_valid = 1'b1;
      e = '{due: due, is_err: 1'b0, value: m_value, valid: 1'b1, dir: m_dir, step: m_step};
      sb.push_back(e);
    end else begin
      m_valid = 1'b0;
      m_dir   = 2'b00;
      if (pat != 7'b1111111) begin
        e = '{due: due, is_err: 1'b1, value: m_value, valid: 1'b0, dir: 2'b00, step: m_step};
        sb.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input logic [6:0] pat, input int hold);
    @(negedge clk);
    seg = pat;
    if (en && pat != m_last) modelAccept(pat, edge_cnt + 6);
    repeat (hold) @(negedge clk);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_value"}, value, 0);
    checkOutput({tag, "_valid"}, valid, 0);
    checkOutput({tag, "_new_val"}, new_val, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_dir"}, dir, 0);
    checkOutput({tag, "_step"}, step_cnt, 0);
  endtask

  task automatic modelReset();
    m_value = 4'h0;
    m_valid = 1'b0;
    m_dir   = 2'b00;
    m_step  = 8'h00;
    m_last  = 7'b1111111;
  endtask

  // Monitor: compare each pulse against the scoreboard head, flag late ones
  always @(negedge clk) begin
    exp_t e;
    if (new_val || err) begin
      checkOutput("exclusive", {31'd0, new_val & err}, 0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_pulse", {30'd0, new_val, err}, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("pulse_edge", edge_cnt, e.due);
        checkOutput("pulse_err", err, e.is_err);
        checkOutput("pulse_new_val", new_val, !e.is_err);
        checkOutput("pulse_value", value, e.value);
        checkOutput("pulse_valid", valid, e.valid);
        checkOutput("pulse_dir", dir, e.dir);
        checkOutput("pulse_step", step_cnt, e.step);
      end
    end else if (sb.size() != 0 && edge_cnt > sb[0].due) begin
      e = sb.pop_front();
      checkOutput("missed_pulse_edge", edge_cnt, e.due);
    end
  end

  initial begin
    // Reset state
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("reset");

    // First glyph after reset: 0
    @(negedge clk);
    seg = glyph_tab[0];
    rst = 1'b1;
    modelAccept(glyph_tab[0], edge_cnt + 6);
    repeat (10) @(negedge clk);

    // Counting down with wrap 0 -> F
    applyStimulus(glyph_tab[3], 10);
    applyStimulus(glyph_tab[2], 10);
    applyStimulus(glyph_tab[1], 10);
    applyStimulus(glyph_tab[0], 10);
    applyStimulus(glyph_tab[15], 10);
    checkOutput("down_value", value, 4'hF);
    checkOutput("down_dir", dir, 2'b10);
    checkOutput("down_step", step_cnt, 4);

    // Wrap F -> 0 counts up
    applyStimulus(glyph_tab[0], 10);
    checkOutput("wrap_up_dir", dir, 2'b01);

    // Short glitch is ignored
    @(negedge clk);
    seg = 7'b1111001;
    repeat (2) @(negedge clk);
    seg = glyph_tab[0];
    repeat (12) @(negedge clk);
    checkOutput("glitch_value", value, 0);
    checkOutput("glitch_valid", valid, 1);
    checkOutput("glitch_dir", dir, 2'b01);
    checkOutput("glitch_step", step_cnt, 4);

    // Unrecognised pattern, then blank
    applyStimulus(7'b1010101, 10);
    checkOutput("bad_valid", valid, 0);
    checkOutput("bad_value", value, 0);
    checkOutput("bad_dir", dir, 0);
    applyStimulus(7'b1111111, 10);
    checkOutput("blank_valid", valid, 0);
    checkOutput("blank_value", value, 0);
    checkOutput("blank_err", err, 0);

    // Enable gating: 5 accepted, 7 held off until en rises
    applyStimulus(glyph_tab[5], 10);
    @(negedge clk);
    en = 1'b0;
    applyStimulus(glyph_tab[7], 10);
    checkOutput("en_off_value", value, 5);
    @(negedge clk);
    en = 1'b1;
    modelAccept(glyph_tab[7], edge_cnt + 1);
    repeat (5) @(negedge clk);
    checkOutput("en_on_value", value, 7);
    checkOutput("en_on_dir", dir, 0);

    // Reset in the middle of filtering a 4
    @(negedge clk);
    seg = glyph_tab[4];
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    modelReset();
    checkReset("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    modelAccept(glyph_tab[4], edge_cnt + 6);
    repeat (10) @(negedge clk);
    checkOutput("after_reset_value", value, 4);
    checkOutput("after_reset_dir", dir, 0);

    checkOutput("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
